// File: rtl/clk_gen_multi_pkg.sv
// Shared encodings for the multi-channel clock generator: channel modes,
// per-channel FSM states and the mode decode helper.
package clk_gen_multi_pkg;

  typedef enum logic [1:0] {
    MODE_OFF   = 2'b00,
    MODE_FREE  = 2'b01,
    MODE_BURST = 2'b10,
    MODE_RSVD  = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_RUN   = 2'b01,
    S_BURST = 2'b10,
    S_DONE  = 2'b11
  } ch_state_e;

  // The reserved encoding behaves exactly like OFF.
  function automatic mode_e decode_mode(input logic [1:0] raw);
    mode_e m;
    case (raw)
      2'b01:   m = MODE_FREE;
      2'b10:   m = MODE_BURST;
      default: m = MODE_OFF;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/clk_gen_multi_channel.sv
// One generated-clock channel: shadow config, half-period counter, burst
// counter and IDLE/RUN/BURST/DONE sequencing. All outputs are flop outputs.
module clk_gen_multi_channel
  import clk_gen_multi_pkg::*;
#(
  parameter int COUNTER_BITS = 32,
  parameter int PULSE_BITS   = 32
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    we_i,
  input  logic                    start_i,
  input  logic                    en_i,
  input  logic [1:0]              mode_i,
  input  logic [COUNTER_BITS-1:0] div_i,
  input  logic [PULSE_BITS-1:0]   pulse_i,
  output logic                    clk_o,
  output logic                    busy_o,
  output logic                    done_o
);

  localparam logic [COUNTER_BITS-1:0] ONE_C = {{(COUNTER_BITS-1){1'b0}}, 1'b1};
  localparam logic [PULSE_BITS-1:0]   ONE_P = {{(PULSE_BITS-1){1'b0}}, 1'b1};

  ch_state_e               state_q, state_d;
  mode_e                   sh_mode_q, sh_mode_d;
  logic [COUNTER_BITS-1:0] sh_div_q, sh_div_d;
  logic [PULSE_BITS-1:0]   sh_pulse_q, sh_pulse_d;
  logic [COUNTER_BITS-1:0] div_q, div_d;
  logic [COUNTER_BITS-1:0] cnt_q, cnt_d;
  logic [PULSE_BITS-1:0]   rem_q, rem_d;
  logic                    clk_q, clk_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic                    at_bound_s;
  logic                    stop_s;

  assign at_bound_s = (cnt_q == div_q);

  // Shadow config always holds the most recent write, including this cycle's.
  always_comb begin
    sh_mode_d  = sh_mode_q;
    sh_div_d   = sh_div_q;
    sh_pulse_d = sh_pulse_q;
    if (we_i) begin
      sh_mode_d  = decode_mode(mode_i);
      sh_div_d   = div_i;
      sh_pulse_d = pulse_i;
    end else begin
      sh_mode_d  = sh_mode_q;
      sh_div_d   = sh_div_q;
      sh_pulse_d = sh_pulse_q;
    end
  end

  // A running channel must wind down once the requested mode no longer matches it.
  always_comb begin
    stop_s = 1'b0;
    if (state_q == S_RUN) begin
      stop_s = (sh_mode_d != MODE_FREE);
    end else if (state_q == S_BURST) begin
      stop_s = (sh_mode_d != MODE_BURST);
    end else begin
      stop_s = 1'b0;
    end
  end

  // Next-state, phase counter, burst counter and output level.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    clk_d   = clk_q;
    div_d   = div_q;
    case (state_q)
      S_IDLE: begin
        clk_d = 1'b0;
        cnt_d = '0;
        div_d = sh_div_d;
        if (sh_mode_d == MODE_FREE) begin
          state_d = S_RUN;
        end else if ((sh_mode_d == MODE_BURST) && start_i) begin
          rem_d = sh_pulse_d;
          if (sh_pulse_d == '0) begin
            state_d = S_DONE;
          end else begin
            state_d = S_BURST;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN, S_BURST: begin
        if (stop_s && !clk_q) begin
          state_d = S_IDLE;
          cnt_d   = '0;
          div_d   = sh_div_d;
        end else if ((state_q == S_BURST) && (rem_q == '0) && !clk_q) begin
          state_d = S_DONE;
          cnt_d   = '0;
        end else if (!en_i && !clk_q) begin
          // Paused: hold low and restart the low phase from scratch on resume.
          cnt_d = '0;
        end else if (at_bound_s) begin
          clk_d = ~clk_q;
          cnt_d = '0;
          div_d = sh_div_d;
          if (!clk_q && (state_q == S_BURST) && (rem_q != '0)) begin
            rem_d = rem_q - ONE_P;
          end else begin
            rem_d = rem_q;
          end
          if (clk_q && stop_s) begin
            state_d = S_IDLE;
          end else begin
            state_d = state_q;
          end
        end else begin
          cnt_d = cnt_q + ONE_C;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        clk_d   = 1'b0;
        cnt_d   = '0;
      end
      default: begin
        state_d = S_IDLE;
        clk_d   = 1'b0;
        cnt_d   = '0;
      end
    endcase
    busy_d = (state_d == S_RUN) || (state_d == S_BURST);
    done_d = (state_d == S_DONE);
  end

  // State and output registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= S_IDLE;
      sh_mode_q  <= MODE_OFF;
      sh_div_q   <= '0;
      sh_pulse_q <= '0;
      div_q      <= '0;
      cnt_q      <= '0;
      rem_q      <= '0;
      clk_q      <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      sh_mode_q  <= sh_mode_d;
      sh_div_q   <= sh_div_d;
      sh_pulse_q <= sh_pulse_d;
      div_q      <= div_d;
      cnt_q      <= cnt_d;
      rem_q      <= rem_d;
      clk_q      <= clk_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign clk_o  = clk_q;
  assign busy_o = busy_q;
  assign done_o = done_q;

endmodule

// File: rtl/clk_gen_multi.sv
// Multi-channel programmable clock generator: decodes the config bus into
// per-channel strobes and instantiates one divider channel per output.
module clk_gen_multi
  import clk_gen_multi_pkg::*;
#(
  parameter int NUM_CH       = 4,
  parameter int COUNTER_BITS = 32,
  parameter int PULSE_BITS   = 32
) (
  input  logic                                        clk,
  input  logic                                        reset,
  input  logic                                        cfg_we,
  input  logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] cfg_ch,
  input  logic [1:0]                                  cfg_mode,
  input  logic [COUNTER_BITS-1:0]                     cfg_div,
  input  logic [PULSE_BITS-1:0]                       cfg_pulse,
  input  logic                                        cfg_start,
  input  logic [NUM_CH-1:0]                           ch_enable,
  output logic [NUM_CH-1:0]                           clk_o,
  output logic [NUM_CH-1:0]                           busy,
  output logic [NUM_CH-1:0]                           done
);

  logic [NUM_CH-1:0] we_s;
  logic [NUM_CH-1:0] start_s;

  // Channel select; an index beyond the last channel selects nothing.
  always_comb begin
    we_s    = '0;
    start_s = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (int'(cfg_ch) == i) begin
        we_s[i]    = cfg_we;
        start_s[i] = cfg_start;
      end else begin
        we_s[i]    = 1'b0;
        start_s[i] = 1'b0;
      end
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    clk_gen_multi_channel #(
      .COUNTER_BITS(COUNTER_BITS),
      .PULSE_BITS  (PULSE_BITS)
    ) u_ch (
      .clk_i  (clk),
      .rst_ni (reset),
      .we_i   (we_s[g]),
      .start_i(start_s[g]),
      .en_i   (ch_enable[g]),
      .mode_i (cfg_mode),
      .div_i  (cfg_div),
      .pulse_i(cfg_pulse),
      .clk_o  (clk_o[g]),
      .busy_o (busy[g]),
      .done_o (done[g])
    );
  end

endmodule
